// File: rtl/wb_pkg.sv
// Shared write-back types: register-file geometry and the queued write request.
package wb_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [REG_DW-1:0] wd;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests; exposes storage and a per-slot
// valid mask so the top can compare queued destinations against decode reads.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [PW:0]           count,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]      valid
);
  logic [PW:0]         wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  wb_req_t [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q[PW-1:0]] = push_data;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    assign valid[i] = ((PW+1)'(PW'(i) - rptr_q[PW-1:0])) < count_q;
  end

  assign head    = mem_q[rptr_q[PW-1:0]];
  assign count   = count_q;
  assign entries = mem_q;
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, long-latency results
// queue in a FIFO. Optional same-cycle ml bypass when idle: define WB_ML_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_wa,
  input  logic [DW-1:0] pipe_wd,
  input  logic          ml_valid,
  output logic          ml_ready,
  input  logic [AW-1:0] ml_wa,
  input  logic [DW-1:0] ml_wd,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          qhit1,
  output logic          qhit2,
  output logic [PW:0]   q_count
);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic          we3_q, we3_d, ml_ready_q, ml_ready_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic                pipe_sel, ml_take, bypass, push, pop, fifo_nempty;
  wb_req_t             ml_req, head;
  logic [PW:0]         count, count_nxt;
  wb_req_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]    fvalid, hit1, hit2;

  assign ml_req      = '{wa: ml_wa, wd: ml_wd};
  assign fifo_nempty = (count != '0);
  assign pipe_sel    = pipe_we && (pipe_wa != '0);
  // Writes to r0 are consumed without ever touching the port or the queue.
  assign ml_take     = ml_valid && ml_ready_q && (ml_wa != '0);

`ifdef WB_ML_BYPASS_EN
  assign bypass = ml_take && !pipe_sel && !fifo_nempty;
`else
  assign bypass = 1'b0;
`endif

  assign push = ml_take && !bypass;
  assign pop  = !pipe_sel && fifo_nempty;

  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (pipe_sel) begin
      we3_d = 1'b1;
      wa3_d = pipe_wa;
      wd3_d = pipe_wd;
    end else if (pop) begin
      we3_d = 1'b1;
      wa3_d = head.wa;
      wd3_d = head.wd;
    end else if (bypass) begin
      we3_d = 1'b1;
      wa3_d = ml_wa;
      wd3_d = ml_wd;
    end
  end

  // Ready tracks next-cycle occupancy so it reflects the count at each cycle start.
  always_comb begin
    count_nxt  = count + (PW+1)'(push) - (PW+1)'(pop);
    ml_ready_d = count_nxt < DEPTH_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      ml_ready_q <= 1'b0;
    end else begin
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      ml_ready_q <= ml_ready_d;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (ml_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .entries   (entries),
    .valid     (fvalid)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit1[i] = fvalid[i] && (entries[i].wa == ra1);
    assign hit2[i] = fvalid[i] && (entries[i].wa == ra2);
  end

  assign qhit1    = |hit1 && (ra1 != '0);
  assign qhit2    = |hit2 && (ra2 != '0);
  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign ml_ready = ml_ready_q;
  assign q_count  = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; expected latency follows WB_ML_BYPASS_EN.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, ml_valid, ml_ready, we3, qhit1, qhit2;
  logic [4:0]  pipe_wa, ml_wa, wa3, ra1, ra2;
  logic [31:0] pipe_wd, ml_wd, wd3;
  logic [2:0]  q_count;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .ml_valid(ml_valid), .ml_ready(ml_ready), .ml_wa(ml_wa), .ml_wd(ml_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .qhit1(qhit1), .qhit2(qhit2), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    ml_valid = 0; ml_wa = 0; ml_wd = 0;
  endtask

  task automatic out(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    chk({tag, "_we"}, we3, we);
    chk({tag, "_wa"}, wa3, wa);
    chk({tag, "_wd"}, wd3, wd);
  endtask

  initial begin
    int  qm[$];
    int  nxt, written, item;
    bit  busy, acc, ewe, from_ml;
    logic [4:0]  ewa;
    logic [31:0] ewd;

    rst = 0; ra1 = 0; ra2 = 0;
    idle_in();
    #2;
    out("rst", 0, 0, 0);
    chk("rst_cnt", q_count, 0);
    chk("rst_rdy", ml_ready, 0);
    @(negedge clk); rst = 1;
    tick();
    chk("rel_rdy", ml_ready, 1);
    chk("rel_we", we3, 0);

    // Pipe priority: r7 held three cycles, ml r5 waits behind it.
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h70;
    ml_valid = 1; ml_wa = 5; ml_wd = 32'hAAAA;
    ra1 = 5; ra2 = 6;
    tick();
    ml_valid = 0;
    out("pri0", 1, 7, 32'h70);
    chk("pri_cnt", q_count, 1);
    chk("pri_hit1a", qhit1, 1);
    chk("pri_hit2", qhit2, 0);
    pipe_wd = 32'h71;
    tick();
    out("pri1", 1, 7, 32'h71);
    chk("pri_hit1b", qhit1, 1);
    pipe_wd = 32'h72;
    tick();
    out("pri2", 1, 7, 32'h72);
    chk("pri_hit1c", qhit1, 1);
    pipe_we = 0;
    tick();
    out("pri_ml", 1, 5, 32'hAAAA);
    chk("pri_hit_clr", qhit1, 0);
    chk("pri_cnt0", q_count, 0);
    tick();
    out("pri_idle", 0, 5, 32'hAAAA);

    // Fill/full with the pipe busy, then drain in order.
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h77;
    for (int i = 1; i <= 4; i++) begin
      ml_valid = 1; ml_wa = 5'(10 + i); ml_wd = 32'h100 + i;
      chk("fill_rdy", ml_ready, 1);
      tick();
    end
    ml_wa = 15; ml_wd = 32'h105;
    chk("full_cnt", q_count, 4);
    chk("full_rdy", ml_ready, 0);
    tick();
    chk("full_cnt2", q_count, 4);
    chk("full_rdy2", ml_ready, 0);
    chk("full_pipe", wa3, 7);
    pipe_we = 0;
    tick();
    out("drain1", 1, 11, 32'h101);
    chk("drain1_rdy", ml_ready, 1);
    chk("drain1_cnt", q_count, 3);
    tick();
    ml_valid = 0;
    out("drain2", 1, 12, 32'h102);
    chk("drain2_cnt", q_count, 3);
    for (int i = 3; i <= 5; i++) begin
      tick();
      out("drainN", 1, 5'(10 + i), 32'h100 + i);
      chk("drainN_cnt", q_count, 3'(5 - i));
    end
    tick();
    chk("drain_idle", we3, 0);

    // Zero register on both producers.
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7;
    ml_valid = 1; ml_wa = 9; ml_wd = 32'h1234;
    tick();
    ml_valid = 0;
    pipe_wa = 0; pipe_wd = 32'hDEAD;
    tick();
    out("zero_pipe", 1, 9, 32'h1234);
    chk("zero_cnt", q_count, 0);
    pipe_we = 0;
    ml_valid = 1; ml_wa = 0; ml_wd = 32'h5555;
    chk("zero_rdy", ml_ready, 1);
    ra1 = 0;
    tick();
    ml_valid = 0;
    out("zero_ml", 0, 9, 32'h1234);
    chk("zero_ml_cnt", q_count, 0);
    chk("zero_qhit", qhit1, 0);
    tick();
    chk("zero_ml_we", we3, 0);

    // Wrap-around: 12 items through a small model, pipe busy 2 of every 4 cycles.
    nxt = 0; written = 0;
    for (int c = 0; c < 100 && written < 12; c++) begin
      busy = (c % 4) < 2;
      pipe_we = busy; pipe_wa = 7; pipe_wd = 32'h7000 + c;
      ml_valid = (nxt < 12); ml_wa = 5'(1 + nxt); ml_wd = 32'hC000 + nxt;
      acc = ml_valid && ml_ready;
      ewe = 1; ewa = 7; ewd = pipe_wd; from_ml = 0;
      if (busy) begin
        if (acc) qm.push_back(nxt);
      end else if (qm.size() > 0) begin
        item = qm.pop_front();
        ewa = 5'(1 + item); ewd = 32'hC000 + item; from_ml = 1;
        if (acc) qm.push_back(nxt);
      end else if (acc) begin
`ifdef WB_ML_BYPASS_EN
        ewa = 5'(1 + nxt); ewd = 32'hC000 + nxt; from_ml = 1;
`else
        qm.push_back(nxt); ewe = 0;
`endif
      end else begin
        ewe = 0;
      end
      tick();
      if (acc) nxt++;
      chk("wrap_we", we3, ewe);
      if (ewe) begin
        chk("wrap_wa", wa3, ewa);
        chk("wrap_wd", wd3, ewd);
      end
      if (from_ml) written++;
      chk("wrap_cnt", q_count, qm.size());
      chk("wrap_le4", q_count <= 4, 1);
      chk("wrap_rdy", ml_ready, qm.size() < 4);
    end
    chk("wrap_all", written, 12);
    idle_in();
    tick();

    // Bypass latency.
    ml_valid = 1; ml_wa = 3; ml_wd = 32'hBEEF;
    tick();
    ml_valid = 0;
`ifdef WB_ML_BYPASS_EN
    out("byp_n", 1, 3, 32'hBEEF);
    chk("byp_cnt", q_count, 0);
`else
    chk("byp_n_we", we3, 0);
    chk("byp_cnt", q_count, 1);
    tick();
    out("byp_n1", 1, 3, 32'hBEEF);
`endif
    tick();
    chk("byp_idle", we3, 0);

    // Reset mid-operation with 3 queued entries and a pending write.
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h99;
    for (int i = 0; i < 3; i++) begin
      ml_valid = 1; ml_wa = 5'(20 + i); ml_wd = 32'h200 + i;
      tick();
    end
    ml_valid = 0;
    chk("mrst_pre_cnt", q_count, 3);
    chk("mrst_pre_we", we3, 1);
    #2; rst = 0; #1;
    out("mrst", 0, 0, 0);
    chk("mrst_cnt", q_count, 0);
    chk("mrst_rdy", ml_ready, 0);
    idle_in();
    @(negedge clk); rst = 1;
    tick();
    chk("mrst_rdy1", ml_ready, 1);
    chk("mrst_cnt1", q_count, 0);
    chk("mrst_we1", we3, 0);
    tick();
    chk("mrst_we2", we3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
